// File: rtl/ar_mux_rr.sv
// N-to-1 arbitrating mux (fixed-select or round-robin) into a one-entry output register.
// One cycle from handshake to y; a stalled y (y_valid && !y_ready) holds and drops all a_ready.
module ar_mux_rr #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] a,
  input  logic [N-1:0]   a_valid,
  output logic [N-1:0]   a_ready,
  input  logic           mode,
  input  logic [$clog2(N)-1:0] sel,
  output logic [W-1:0]   y,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [$clog2(N)-1:0] y_ch
);

  localparam int SW = $clog2(N);

  logic [(1<<SW)-1:0] av_pad;
  logic [SW-1:0]      ptr;
  logic [SW-1:0]      gnt_idx;
  logic               gnt_vld;
  logic               load_en;
  logic [W-1:0]       gnt_dat;

  assign load_en = !y_valid || y_ready;

  always_comb begin
    // Zero-padding to a power of two makes sel >= N read as no request.
    av_pad = '0;
    av_pad[N-1:0] = a_valid;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!mode) begin
      if (av_pad[sel]) begin
        gnt_vld = 1'b1;
        gnt_idx = sel;
      end
    end else begin
      // Walk downward so the channel nearest ptr is the last (winning) assignment.
      for (int k = N - 1; k >= 0; k--) begin
        if (a_valid[(int'(ptr) + k) % N]) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'((int'(ptr) + k) % N);
        end
      end
    end
  end

  assign gnt_dat = a[int'(gnt_idx)*W +: W];
  assign a_ready = (rst_n && load_en && gnt_vld) ? (N'(1) << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
      ptr     <= '0;
    end else if (load_en) begin
      if (gnt_vld) begin
        y       <= gnt_dat;
        y_ch    <= gnt_idx;
        y_valid <= 1'b1;
        if (mode) begin
          ptr <= (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ar_mux_rr.md
AR_MUX_RR -- requirements
Module: ar_mux_rr

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning number of input channels, legal 2..16.
REQ-002 The block SHALL have parameter W, default 8, meaning data width per channel, legal 1..64.
REQ-003 The block SHALL have derived localparam SW = clog2(N), meaning select and channel-index width, not overridable.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, meaning reset; synchronous, active-low.
REQ-006 The block SHALL have port a, input, N*W bits, meaning channel data, channel i at a[i*W +: W].
REQ-007 The block SHALL have port a_valid, input, N bits, meaning channel i has a word.
REQ-008 The block SHALL have port a_ready, output, N bits, meaning channel i word accepted this cycle.
REQ-009 The block SHALL have port mode, input, 1 bit, meaning 0 = fixed select, 1 = round-robin.
REQ-010 The block SHALL have port sel, input, SW bits, meaning channel chosen in fixed mode.
REQ-011 The block SHALL have port y, output, W bits, meaning registered output data.
REQ-012 The block SHALL have port y_valid, output, 1 bit, meaning y holds a word.
REQ-013 The block SHALL have port y_ready, input, 1 bit, meaning downstream accepts y this cycle.
REQ-014 The block SHALL have port y_ch, output, SW bits, meaning source channel index of the word in y.

Function
REQ-015 The output SHALL be a one-entry register; load_en = !y_valid || y_ready.
REQ-016 In mode 0, grant SHALL go to channel sel when a_valid[sel]=1 and sel<N; otherwise no grant.
REQ-017 In mode 1, grant SHALL go to the first channel with a_valid=1 searching from ptr upward, wrapping N-1 -> 0.
REQ-018 a_ready[i] SHALL be combinational: load_en && grant==i; at most one bit set per cycle.
REQ-019 On a handshake (a_valid[i] && a_ready[i]), the next edge SHALL set y = channel i data, y_ch = i, y_valid = 1; latency 1 cycle.
REQ-020 When load_en=1, y_valid=1 and no grant exists, the next edge SHALL clear y_valid; y and y_ch hold their values.
REQ-021 While y_valid && !y_ready, y, y_ch and y_valid SHALL be stable and a_ready SHALL be all zero.
REQ-022 Simultaneous drain and load SHALL sustain one word per cycle with no bubble.
REQ-023 ptr (SW bits) SHALL update to (granted+1) mod N only on a mode-1 handshake; in mode 0 ptr SHALL hold.
REQ-024 A mode or sel change SHALL affect only the grant of the cycle in which it is sampled; the word already in y is unaffected.
REQ-025 Outputs SHALL never be X when inputs are known; sel>=N SHALL be treated as no request.

Reset
REQ-026 When rst_n=0 at an edge, y_valid, y, y_ch and ptr SHALL all clear to 0, overriding any handshake in that cycle.
REQ-027 While rst_n=0, a_ready SHALL be all zero.
REQ-028 Reset asserted mid-stream SHALL discard the held word without a y_ready handshake.

Verification
REQ-029 Verification (N=4, W=8): mode 0, sel=2, a_valid=4'b0100, word 8'hA5 on ch2, y_ready=1 -> a_ready=4'b0100; next cycle y=8'hA5, y_ch=2, y_valid=1.
REQ-030 Verification: mode 1, a_valid=4'b1111 held, y_ready=1 -> y_ch sequence 0,1,2,3,0, one word per cycle.
REQ-031 Verification: mode 1, ptr=3, a_valid=4'b0010 -> grant ch1; ptr becomes 2.
REQ-032 Verification: y_valid=1, y_ready=0 for 3 cycles with a_valid=4'b1111 -> y and y_ch stable; a_ready=0 throughout.
REQ-033 Verification: mode 0, sel=1, a_valid[1]=0, other channels valid -> no grant; y_valid falls after drain.
REQ-034 Verification: rst_n=0 for one cycle while y_valid=1 and a handshake is pending -> y_valid=0, y=0, y_ch=0, ptr=0 next cycle; no word accepted.
